instr_fetch: RTL

Instruction fetch stage of the RV32 core: owns the program counter, issues word reads to instruction memory over a request/acknowledge handshake and buffers returned words in a 2-entry prefetch FIFO. It drives `instruction`/address pairs into the decode stage, honours the decode stage's busy back-pressure and redirects on branch/jump/trap flushes. Empty slots are filled with a canonical NOP so downstream stages never see an undefined word.

---
 rtl/instr_fetch.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// RV32 instruction fetch stage: PC ownership, single-outstanding word fetch,
// 2-entry prefetch FIFO and registered instruction/address hand-off to decode.
module instr_fetch #(
    parameter int              XLEN         = 32,
    parameter int              IF_LEN       = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [IF_LEN-1:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              i_busy,
    output logic              o_busy,
    input  logic              i_flush,
    input  logic [XLEN-1:0]   i_target,
    output logic              o_req,
    output logic [XLEN-1:0]   o_addr,
    input  logic              i_ack,
    input  logic [IF_LEN-1:0] i_rdata,
    input  logic              i_err,
    output logic [IF_LEN-1:0] instruction,
    output logic [XLEN-1:0]   o_address,
    output logic              o_valid,
    output logic              o_fault
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        FULL = 2'd1,
        DROP = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] RESET_PC = {RESET_VECTOR[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};

    state_t            state_r;
    logic [XLEN-1:0]   pc_r;
    logic [1:0]        count_r;
    logic              rd_ptr_r;
    logic              wr_ptr_r;
    logic [IF_LEN-1:0] fifo_data_r [2];
    logic [XLEN-1:0]   fifo_addr_r [2];
    logic              fifo_err_r  [2];

    logic              ack_s;
    logic              push_s;
    logic              take_s;
    logic [1:0]        count_next_s;
    logic [XLEN-1:0]   pc_inc_s;
    logic [XLEN-1:0]   target_s;
    logic              unused_s;

    assign unused_s = ^i_target[1:0];
    assign o_busy   = i_busy | (count_r == 2'd2);

    // Handshake qualification and FIFO occupancy after this edge
    always_comb begin
        ack_s        = clk_en & i_ack & o_req;
        push_s       = ack_s & ~i_flush & (state_r == REQ);
        take_s       = clk_en & ~i_busy & ~i_flush & (count_r != 2'd0);
        count_next_s = count_r + {1'b0, push_s} - {1'b0, take_s};
        pc_inc_s     = pc_r + PC_STEP;
        target_s     = {i_target[XLEN-1:2], 2'b00};
    end

    // Fetch FSM: owns PC and the memory request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= REQ;
            pc_r    <= RESET_PC;
            o_req   <= 1'b0;
            o_addr  <= RESET_PC;
        end else if (clk_en) begin
            if (i_flush) begin
                pc_r <= target_s;
                // An unacked request must stay stable on the bus until its ack
                if (o_req && !ack_s) begin
                    state_r <= DROP;
                end else begin
                    state_r <= REQ;
                    o_req   <= 1'b0;
                    o_addr  <= target_s;
                end
            end else begin
                case (state_r)
                    REQ: begin
                        if (ack_s) begin
                            pc_r   <= pc_inc_s;
                            o_addr <= pc_inc_s;
                            if (i_err) begin
                                state_r <= HALT;
                                o_req   <= 1'b0;
                            end else if (count_next_s == 2'd2) begin
                                state_r <= FULL;
                                o_req   <= 1'b0;
                            end else begin
                                o_req <= 1'b1;
                            end
                        end else if (!o_req) begin
                            o_req  <= 1'b1;
                            o_addr <= pc_r;
                        end
                    end
                    FULL: begin
                        if (take_s) begin
                            state_r <= REQ;
                            o_req   <= 1'b1;
                            o_addr  <= pc_r;
                        end
                    end
                    DROP: begin
                        if (ack_s) begin
                            state_r <= REQ;
                            o_req   <= 1'b0;
                            o_addr  <= pc_r;
                        end
                    end
                    HALT: begin
                        o_req <= 1'b0;
                    end
                    default: begin
                        state_r <= REQ;
                        o_req   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Prefetch FIFO and decode-facing output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r        <= 2'd0;
            rd_ptr_r       <= 1'b0;
            wr_ptr_r       <= 1'b0;
            fifo_data_r[0] <= NOP_WORD;
            fifo_data_r[1] <= NOP_WORD;
            fifo_addr_r[0] <= RESET_PC;
            fifo_addr_r[1] <= RESET_PC;
            fifo_err_r[0]  <= 1'b0;
            fifo_err_r[1]  <= 1'b0;
            instruction    <= NOP_WORD;
            o_address      <= {XLEN{1'b0}};
            o_valid        <= 1'b0;
            o_fault        <= 1'b0;
        end else if (clk_en) begin
            if (i_flush) begin
                count_r     <= 2'd0;
                rd_ptr_r    <= 1'b0;
                wr_ptr_r    <= 1'b0;
                instruction <= NOP_WORD;
                o_valid     <= 1'b0;
                o_fault     <= 1'b0;
            end else begin
                if (push_s) begin
                    fifo_data_r[wr_ptr_r] <= i_rdata;
                    fifo_addr_r[wr_ptr_r] <= o_addr;
                    fifo_err_r[wr_ptr_r]  <= i_err;
                    wr_ptr_r              <= ~wr_ptr_r;
                end
                // A word pushed into an empty FIFO is only visible next edge
                if (take_s) begin
                    rd_ptr_r    <= ~rd_ptr_r;
                    instruction <= fifo_err_r[rd_ptr_r] ? NOP_WORD : fifo_data_r[rd_ptr_r];
                    o_address   <= fifo_addr_r[rd_ptr_r];
                    o_fault     <= fifo_err_r[rd_ptr_r];
                    o_valid     <= 1'b1;
                end else if (!i_busy) begin
                    instruction <= NOP_WORD;
                    o_valid     <= 1'b0;
                    o_fault     <= 1'b0;
                end
                count_r <= count_next_s;
            end
        end
    end

endmodule
